// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
//   state_t   : arbiter FSM encoding (IDLE, ACCESS, RESP)
//   DEF_DW/AW : default data / address widths
package mem_arbiter_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker2.sv
// Two-way round-robin picker.
//   req0, req1 : request levels
//   last       : index granted most recently
//   winner     : index of the selected requester (meaningful when valid)
//   valid      : at least one request present
module rr_picker2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        // Under contention the one not served last goes; otherwise whoever asks.
        if (req0 && req1) begin
            winner = ~last;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with a fixed 3-cycle IDLE/ACCESS/RESP sequence.
//   clock, reset          : clock, asynchronous active-high reset
//   req*/we*/addr*/wdata* : requester command inputs, sampled only in IDLE
//   done0/done1           : one-cycle completion pulse in RESP for the winner
//   rdata                 : registered read result, updated only by reads
//   busy                  : FSM not in IDLE
//   mem_re/mem_we         : memory strobes, only ever high in ACCESS
//   mem_addr/mem_wdata    : memory address / write data, held outside ACCESS
//   mem_rdata             : combinational memory read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          lat_idx_q, lat_idx_d;
    logic          lat_we_q, lat_we_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [DW-1:0] lat_wdata_q, lat_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic pick_idx;
    logic pick_vld;

    rr_picker2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lat_idx_d   = lat_idx_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = ACCESS;
                    last_d      = pick_idx;
                    lat_idx_d   = pick_idx;
                    lat_we_d    = pick_idx ? we1    : we0;
                    lat_addr_d  = pick_idx ? addr1  : addr0;
                    lat_wdata_d = pick_idx ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Remember the last driven write data so the bus value holds after ACCESS.
                if (lat_we_q) begin
                    mem_wdata_d = lat_wdata_q;
                end else begin
                    rdata_d = mem_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            lat_idx_q   <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lat_idx_q   <= lat_idx_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // All outputs decode from registered state, so reset takes effect at once.
    assign busy      = (state_q != IDLE);
    assign mem_we    = (state_q == ACCESS) &&  lat_we_q;
    assign mem_re    = (state_q == ACCESS) && !lat_we_q;
    // Latched address only changes on a new win, so it holds between accesses.
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = mem_we ? lat_wdata_q : mem_wdata_q;
    assign done0     = (state_q == RESP) && !lat_idx_q;
    assign done1     = (state_q == RESP) &&  lat_idx_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        done0, done1, busy, mem_re, mem_we;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic [15:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    mem_arbiter #(.DW(16), .AW(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("excl_done", {31'b0, done0 & done1}, 32'd0);
        chk("excl_strobe", {31'b0, mem_re & mem_we}, 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {30'b0, done1, done0}, 0);
        chk("rst_strobe", {30'b0, mem_re, mem_we}, 0);
        chk("rst_rdata", {16'b0, rdata}, 0);
        chk("rst_maddr", {24'b0, mem_addr}, 0);
        chk("rst_mwdata", {16'b0, mem_wdata}, 0);
        @(negedge clock); reset = 1'b0;
        tick();

        // single requester write then read
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 16'hBEEF;
        tick();
        chk("wr_we", {31'b0, mem_we}, 1);
        chk("wr_re", {31'b0, mem_re}, 0);
        chk("wr_addr", {24'b0, mem_addr}, 32'h10);
        chk("wr_data", {16'b0, mem_wdata}, 32'hBEEF);
        chk("wr_busy", {31'b0, busy}, 1);
        chk("wr_nodone", {30'b0, done1, done0}, 0);
        req0 = 0; we0 = 0; addr0 = 8'hFF; wdata0 = 16'h0;
        tick();
        chk("wr_done", {30'b0, done1, done0}, 32'b01);
        chk("wr_we_off", {31'b0, mem_we}, 0);
        chk("wr_hold_addr", {24'b0, mem_addr}, 32'h10);
        chk("wr_hold_data", {16'b0, mem_wdata}, 32'hBEEF);
        tick();
        chk("wr_idle", {30'b0, done1, busy}, 0);
        chk("wr_done_pulse", {31'b0, done0}, 0);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        chk("rd_re", {30'b0, mem_re, mem_we}, 32'b10);
        req0 = 0;
        tick();
        chk("rd_done", {30'b0, done1, done0}, 32'b01);
        chk("rd_data", {16'b0, rdata}, 32'hBEEF);
        tick();

        // reset in the middle of a write access
        req0 = 1; we0 = 1; addr0 = 8'h60; wdata0 = 16'h6666;
        tick();
        chk("ra_we", {31'b0, mem_we}, 1);
        req0 = 0;
        #2 reset = 1'b1;
        #1;
        chk("ra_we_drop", {31'b0, mem_we}, 0);
        chk("ra_busy", {31'b0, busy}, 0);
        chk("ra_rdata", {16'b0, rdata}, 0);
        chk("ra_addr", {24'b0, mem_addr}, 0);
        tick();
        chk("ra_nodone", {30'b0, done1, done0}, 0);

        // contention from reset: 0,1,0,1 (0 first despite 0 having won before reset)
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 8'h41; wdata1 = 16'h2222;
        @(negedge clock); reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("ct_addr", {24'b0, mem_addr}, (g % 2) ? 32'h41 : 32'h40);
            chk("ct_data", {16'b0, mem_wdata}, (g % 2) ? 32'h2222 : 32'h1111);
            tick();
            chk("ct_done", {30'b0, done1, done0}, (g % 2) ? 32'b10 : 32'b01);
            tick();
            chk("ct_gap", {30'b0, done1, done0}, 0);
        end
        req0 = 0; req1 = 0; we1 = 0;
        tick(); tick(); tick();
        chk("ct_quiet", {31'b0, busy}, 0);

        // late arrival of req1 during requester 0's access
        req0 = 1; we0 = 0; addr0 = 8'h40;
        tick();
        chk("la_re", {31'b0, mem_re}, 1);
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 8'h50; wdata1 = 16'h5555;
        tick();
        chk("la_done0", {30'b0, done1, done0}, 32'b01);
        chk("la_rdata", {16'b0, rdata}, 32'h1111);
        tick();
        chk("la_idle", {31'b0, busy}, 0);
        tick();
        chk("la_acc1", {24'b0, mem_addr}, 32'h50);
        chk("la_we1", {31'b0, mem_we}, 1);
        req1 = 0; we1 = 0;
        tick();
        chk("la_done1", {30'b0, done1, done0}, 32'b10);
        tick();

        // rdata holds through a write
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'h1234;
        tick(); req0 = 0; tick(); tick();
        req1 = 1; we1 = 0; addr1 = 8'h20;
        tick(); req1 = 0; tick();
        chk("hd_done1", {30'b0, done1, done0}, 32'b10);
        chk("hd_rdata", {16'b0, rdata}, 32'h1234);
        tick();
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 16'hAAAA;
        tick();
        chk("hd_we", {31'b0, mem_we}, 1);
        chk("hd_acc", {16'b0, rdata}, 32'h1234);
        req0 = 0;
        tick();
        chk("hd_resp", {16'b0, rdata}, 32'h1234);
        chk("hd_done0", {30'b0, done1, done0}, 32'b01);
        tick();
        chk("hd_idle", {16'b0, rdata}, 32'h1234);
        chk("hd_mem", {16'b0, mem[8'h30]}, 32'hAAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
